// File: rtl/gpu_fb_writer.sv
// Framebuffer write-port driver for the GPU pixel stream: optional back-buffer clear,
// 2-stage coordinate-to-address pipe, vblank-synchronised bank swap. Optional: FB_CLEAR_EN.
module gpu_fb_writer #(
   parameter int unsigned H_RES   = 800,
   parameter int unsigned V_RES   = 600,
   parameter int unsigned COLOR_W = 8,
   parameter int unsigned COORD_W = 11,
   localparam int unsigned ADDR_W = $clog2(H_RES * V_RES)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_req,
   input  logic [COLOR_W-1:0] clear_color,
   input  logic               pix_valid,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               frame_end,
   input  logic               vblank,
   output logic               fb_wr_en,
   output logic               fb_wr_bank,
   output logic [ADDR_W-1:0]  fb_wr_addr,
   output logic [COLOR_W-1:0] fb_wr_data,
   output logic               disp_bank,
   output logic               ready,
   output logic               frame_done,
   output logic               overrun,
   output logic [15:0]        drop_cnt
);

   localparam int unsigned PIX_N = H_RES * V_RES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DRAW  = 2'd2,
      ST_SWAP  = 2'd3
   } state_t;

   state_t state;
   state_t state_d;

   logic               s1_valid;
   logic               s1_write;
   logic [ADDR_W-1:0]  s1_yoff;
   logic [ADDR_W-1:0]  s1_x;
   logic [COLOR_W-1:0] s1_color;
   logic               s2_valid;
   logic               end_seen;

   logic pix_take_c;
   logic in_range_c;
   logic clr_last_c;
   logic drained_c;

   assign pix_take_c = pix_valid && (state == ST_DRAW);
   assign in_range_c = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
   assign clr_last_c = (state == ST_CLEAR) && (fb_wr_addr == LAST_ADDR);
   // Nothing accepted this cycle and both pipe stages empty.
   assign drained_c  = !pix_take_c && !s1_valid && !s2_valid;

`ifndef FB_CLEAR_EN
   logic unused_c;
   assign unused_c = ^clear_color;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         ST_IDLE: begin
            if (frame_req) begin
`ifdef FB_CLEAR_EN
               state_d = ST_CLEAR;
`else
               state_d = ST_DRAW;
`endif
            end
         end
         ST_CLEAR: if (clr_last_c) state_d = ST_DRAW;
         ST_DRAW:  if ((end_seen || frame_end) && drained_c) state_d = ST_SWAP;
         ST_SWAP:  if (vblank) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Pixel pipe, clear sweep, bank control and status.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fb_wr_en   <= 1'b0;
         fb_wr_bank <= 1'b1;
         fb_wr_addr <= '0;
         fb_wr_data <= '0;
         disp_bank  <= 1'b0;
         ready      <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         drop_cnt   <= '0;
         s1_valid   <= 1'b0;
         s1_write   <= 1'b0;
         s1_yoff    <= '0;
         s1_x       <= '0;
         s1_color   <= '0;
         s2_valid   <= 1'b0;
         end_seen   <= 1'b0;
      end else begin
         fb_wr_en   <= 1'b0;
         frame_done <= 1'b0;
         ready      <= (state_d == ST_DRAW);

         if (pix_valid && (state != ST_DRAW)) overrun <= 1'b1;

         if (state == ST_DRAW) begin
            if (frame_end) end_seen <= 1'b1;
         end else begin
            end_seen <= 1'b0;
         end

         s1_valid <= pix_take_c;
         s2_valid <= s1_valid;
         if (pix_take_c) begin
            s1_write <= in_range_c && (pix_color != '0);
            s1_yoff  <= ADDR_W'(pix_y) * ADDR_W'(H_RES);
            s1_x     <= ADDR_W'(pix_x);
            s1_color <= pix_color;
            if (!in_range_c && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
         end

         if (s1_valid && s1_write) begin
            fb_wr_en   <= 1'b1;
            fb_wr_addr <= s1_yoff + s1_x;
            fb_wr_data <= s1_color;
         end

         unique case (state)
            ST_IDLE: begin
               if (frame_req) begin
                  drop_cnt <= '0;
`ifdef FB_CLEAR_EN
                  fb_wr_en   <= 1'b1;
                  fb_wr_addr <= '0;
                  fb_wr_data <= clear_color;
`endif
               end
            end
            ST_CLEAR: begin
               if (!clr_last_c) begin
                  fb_wr_en   <= 1'b1;
                  fb_wr_addr <= fb_wr_addr + ADDR_W'(1);
               end
            end
            ST_SWAP: begin
               if (vblank) begin
                  disp_bank  <= ~disp_bank;
                  fb_wr_bank <= ~fb_wr_bank;
                  frame_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed bench for gpu_fb_writer: reset, prepare, pixel table, streaming, swap, overrun,
// reset during preparation. Follows FB_CLEAR_EN; the clear build uses a short frame height.
module tb_gpu_fb_writer;

   localparam int unsigned TB_H = 800;
`ifdef FB_CLEAR_EN
   localparam int unsigned TB_V    = 16;
   localparam int unsigned EXP_CLR = TB_H * TB_V;
`else
   localparam int unsigned TB_V    = 600;
   localparam int unsigned EXP_CLR = 0;
`endif
   localparam int unsigned TB_AW = $clog2(TB_H * TB_V);

   logic             clk;
   logic             reset_n;
   logic             frame_req;
   logic [7:0]       clear_color;
   logic             pix_valid;
   logic [7:0]       pix_color;
   logic [10:0]      pix_x;
   logic [10:0]      pix_y;
   logic             frame_end;
   logic             vblank;
   logic             fb_wr_en;
   logic             fb_wr_bank;
   logic [TB_AW-1:0] fb_wr_addr;
   logic [7:0]       fb_wr_data;
   logic             disp_bank;
   logic             ready;
   logic             frame_done;
   logic             overrun;
   logic [15:0]      drop_cnt;

   gpu_fb_writer #(.H_RES(TB_H), .V_RES(TB_V), .COLOR_W(8), .COORD_W(11)) dut (
      .clk(clk), .reset_n(reset_n), .frame_req(frame_req), .clear_color(clear_color),
      .pix_valid(pix_valid), .pix_color(pix_color), .pix_x(pix_x), .pix_y(pix_y),
      .frame_end(frame_end), .vblank(vblank), .fb_wr_en(fb_wr_en), .fb_wr_bank(fb_wr_bank),
      .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .disp_bank(disp_bank), .ready(ready),
      .frame_done(frame_done), .overrun(overrun), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pix(input bit v, input int x, input int y, input int c);
      pix_valid = v;
      pix_x     = 11'(x);
      pix_y     = 11'(y);
      pix_color = 8'(c);
   endtask

   typedef struct {
      int x;
      int y;
      int color;
      bit wr;
      int addr;
      int drop;
   } vec_t;

   vec_t vt[8];

   initial begin
      int wr_cnt;
      int budget;
      bit seq_ok;
      bit hold_ok;

      vt[0] = '{x: 3,    y: 2,    color: 'h5A, wr: 1'b1, addr: 1603,  drop: 0};
      vt[1] = '{x: 10,   y: 10,   color: 'h00, wr: 1'b0, addr: 0,     drop: 0};
      vt[2] = '{x: 800,  y: 5,    color: 'h07, wr: 1'b0, addr: 0,     drop: 1};
      vt[3] = '{x: 799,  y: 15,   color: 'hFF, wr: 1'b1, addr: 12799, drop: 1};
      vt[4] = '{x: 0,    y: 0,    color: 'h01, wr: 1'b1, addr: 0,     drop: 1};
      vt[5] = '{x: 0,    y: 600,  color: 'h03, wr: 1'b0, addr: 0,     drop: 2};
      vt[6] = '{x: 2047, y: 2047, color: 'h01, wr: 1'b0, addr: 0,     drop: 3};
      vt[7] = '{x: 5,    y: 0,    color: 'h80, wr: 1'b1, addr: 5,     drop: 3};

      reset_n = 1'b0; frame_req = 1'b0; clear_color = 8'h00; frame_end = 1'b0; vblank = 1'b0;
      drive_pix(1'b0, 0, 0, 0);
      step(); step();
      chk("rst_wr_en", fb_wr_en, 0);
      chk("rst_wr_bank", fb_wr_bank, 1);
      chk("rst_wr_addr", fb_wr_addr, 0);
      chk("rst_disp_bank", disp_bank, 0);
      chk("rst_ready", ready, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      reset_n = 1'b1;
      step();
      chk("idle_ready", ready, 0);

      // Prepare back buffer: every clear write sequential, bank 1, clear colour.
      clear_color = 8'h11; frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      wr_cnt = 0; budget = 0; seq_ok = 1'b1;
      while (!ready && budget < int'(EXP_CLR) + 10) begin
         if (fb_wr_en) begin
            if (int'(fb_wr_addr) != wr_cnt || fb_wr_bank != 1'b1 || fb_wr_data != 8'h11)
               seq_ok = 1'b0;
            wr_cnt++;
         end
         step();
         budget++;
      end
      chk("clear_writes", wr_cnt, EXP_CLR);
      chk("clear_sequence", seq_ok, 1);
      chk("ready_after_prep", ready, 1);
      chk("no_write_after_prep", fb_wr_en, 0);

      // Isolated pixels, 2-cycle latency.
      for (int i = 0; i < 8; i++) begin
         drive_pix(1'b1, vt[i].x, vt[i].y, vt[i].color);
         step();
         drive_pix(1'b0, 0, 0, 0);
         step();
         chk($sformatf("vec%0d_wr_en", i), fb_wr_en, vt[i].wr);
         if (vt[i].wr) begin
            chk($sformatf("vec%0d_addr", i), fb_wr_addr, vt[i].addr);
            chk($sformatf("vec%0d_data", i), fb_wr_data, vt[i].color);
            chk($sformatf("vec%0d_bank", i), fb_wr_bank, 1);
         end
         chk($sformatf("vec%0d_drop", i), drop_cnt, vt[i].drop);
      end

      // Back-to-back pixels, one per cycle.
      drive_pix(1'b1, 1, 0, 'h21);
      step();
      drive_pix(1'b1, 2, 0, 'h22);
      step();
      chk("b2b_a_addr", fb_wr_addr, 1);
      chk("b2b_a_data", fb_wr_data, 'h21);
      drive_pix(1'b1, 4, 3, 'h23);
      step();
      chk("b2b_b_addr", fb_wr_addr, 2);
      chk("b2b_b_en", fb_wr_en, 1);
      drive_pix(1'b0, 0, 0, 0);
      step();
      chk("b2b_c_addr", fb_wr_addr, 2404);
      chk("b2b_c_data", fb_wr_data, 'h23);
      step();
      chk("b2b_idle_en", fb_wr_en, 0);

      // frame_end with a pixel in the same cycle; swap waits for vblank.
      drive_pix(1'b1, 1, 1, 'h09); frame_end = 1'b1;
      step();
      drive_pix(1'b0, 0, 0, 0); frame_end = 1'b0;
      step();
      chk("last_pix_en", fb_wr_en, 1);
      chk("last_pix_addr", fb_wr_addr, 801);
      chk("last_pix_data", fb_wr_data, 'h09);
      budget = 0;
      while (ready && budget < 8) begin
         step();
         budget++;
      end
      chk("swap_entered", ready, 0);
      hold_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (frame_done || disp_bank || fb_wr_en) hold_ok = 1'b0;
         step();
      end
      chk("swap_holds_without_vblank", hold_ok, 1);
      vblank = 1'b1;
      step();
      chk("swap_disp_bank", disp_bank, 1);
      chk("swap_wr_bank", fb_wr_bank, 0);
      chk("swap_frame_done", frame_done, 1);
      vblank = 1'b0;
      step();
      chk("frame_done_pulse", frame_done, 0);
      chk("idle_ready_after_swap", ready, 0);

      // Pixel in IDLE: ignored, sticky overrun.
      drive_pix(1'b1, 5, 5, 'h03);
      step();
      drive_pix(1'b0, 0, 0, 0);
      step();
      chk("idle_pix_no_write", fb_wr_en, 0);
      chk("idle_pix_overrun", overrun, 1);
      chk("drop_held_in_idle", drop_cnt, 3);

      // Second frame targets bank 0; drop_cnt cleared, overrun stays.
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
      chk("drop_cleared", drop_cnt, 0);
      budget = 0;
      while (!ready && budget < int'(EXP_CLR) + 10) begin
         step();
         budget++;
      end
      chk("ready_frame2", ready, 1);
      drive_pix(1'b1, 3, 2, 'h5A);
      step();
      drive_pix(1'b0, 0, 0, 0);
      step();
      chk("f2_en", fb_wr_en, 1);
      chk("f2_addr", fb_wr_addr, 1603);
      chk("f2_bank", fb_wr_bank, 0);
      chk("overrun_sticky", overrun, 1);

      // Immediate swap when vblank already high.
      vblank = 1'b1; frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      budget = 0;
      while (!frame_done && budget < 8) begin
         step();
         budget++;
      end
      chk("swap2_frame_done", frame_done, 1);
      chk("swap2_disp_bank", disp_bank, 0);
      vblank = 1'b0;
      step();

      // Reset during preparation.
      frame_req = 1'b1;
      step();
      frame_req = 1'b0;
`ifdef FB_CLEAR_EN
      budget = 0;
      while (int'(fb_wr_addr) != 1000 && budget < 1100) begin
         step();
         budget++;
      end
      chk("clear_reached_1000", fb_wr_addr, 1000);
`else
      step(); step();
`endif
      reset_n = 1'b0;
      step();
      chk("midrst_wr_en", fb_wr_en, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_disp_bank", disp_bank, 0);
      chk("midrst_wr_bank", fb_wr_bank, 1);
      chk("midrst_overrun", overrun, 0);
      reset_n = 1'b1;
      step(); step();
      chk("post_rst_idle_en", fb_wr_en, 0);
      chk("post_rst_idle_ready", ready, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
